// File: rtl/fpu_bist_pkg.sv
// Shared definitions for the FPU comparator self-test blocks: states, sweep
// counters, mantissa patterns, LFSR polynomial and IEEE-754 helpers.
package fpu_bist_pkg;

    localparam int unsigned MANT_W = 23;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SWEEP_A = 3'd1,
        SWEEP_B = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } bist_state_t;

    // Sweep counters; SWEEP_B reuses i/s1/s2 and adds b/r.
    typedef struct packed {
        logic [7:0] i;
        logic [7:0] j;
        logic       s1;
        logic       s2;
        logic [3:0] it;
        logic [3:0] jt;
        logic [4:0] b;
        logic [3:0] r;
    } sweep_cnt_t;

    localparam logic [MANT_W-1:0] MANT_ZERO   = 23'h000000;
    localparam logic [MANT_W-1:0] MANT_ONE    = 23'h000001;
    localparam logic [MANT_W-1:0] MANT_TWO    = 23'h000002;
    localparam logic [MANT_W-1:0] MANT_MID3   = 23'h380000;
    localparam logic [MANT_W-1:0] MANT_MSB    = 23'h400000;
    localparam logic [MANT_W-1:0] MANT_MSB_LO = 23'h5FFFFF;
    localparam logic [MANT_W-1:0] MANT_ONES   = 23'h7FFFFF;

    // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    function automatic logic nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ (x[0] ? LFSR_POLY : 32'd0);
    endfunction

    function automatic logic [MANT_W-1:0] mant_pat(input logic [3:0] k,
                                                   input logic [MANT_W-1:0] rnd);
        logic [MANT_W-1:0] m;
        case (k)
            4'd0:    m = MANT_ZERO;
            4'd1:    m = MANT_ONE;
            4'd2:    m = MANT_TWO;
            4'd3:    m = MANT_MID3;
            4'd4:    m = MANT_MSB;
            4'd5:    m = MANT_MSB_LO;
            4'd6:    m = MANT_ONES;
            default: m = rnd;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/feq_ref_model.sv
// Combinational IEEE-754 single-precision equality reference: +0 == -0,
// NaN never equal and raises the invalid flag.
module feq_ref_model
    import fpu_bist_pkg::*;
(
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        exp_y_c,
    output logic        exp_exc_c
);

    always_comb begin
        exp_exc_c = nan(x1) || nan(x2);
        exp_y_c   = !exp_exc_c &&
                    ((x1 == x2) || ((x1[30:0] == 31'd0) && (x2[30:0] == 31'd0)));
    end

endmodule

// File: rtl/feq_bist.sv
// Self-test initiator for the feq comparator: drives swept operand pairs,
// checks feq results one cycle later, counts mismatches, keeps the first.
module feq_bist
    import fpu_bist_pkg::*;
#(
    parameter int unsigned EXP_MAX   = 255,
    parameter logic [31:0] LFSR_SEED = 32'hACE12345
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [31:0] fail_x1,
    output logic [31:0] fail_x2,
    output logic [31:0] feq_x1,
    output logic [31:0] feq_x2,
    input  logic        feq_y,
    input  logic        feq_exception
);

    localparam logic [7:0] I_LAST_A = 8'(EXP_MAX);
    localparam logic [7:0] I_LAST_B = (EXP_MAX > 254) ? 8'd254 : 8'(EXP_MAX);
    localparam logic [3:0] PAT_LAST = 4'd9;
    localparam logic [4:0] B_LAST   = 5'd22;

    bist_state_t state, state_nxt;
    sweep_cnt_t  cnt, cnt_nxt;
    logic        run_start, lo_wrap;

    logic [31:0] lfsr, lfsr_nxt;
    logic [31:0] vx1, vx2;
    logic [MANT_W-1:0] m1, tmask;
    logic        vec_valid, chk_valid, exp_y_q, exp_exc_q, exp_y, exp_exc;
    logic        mismatch, busy_nxt, done_nxt, pass_nxt;
    logic [15:0] err_nxt;
    logic [31:0] fail_x1_nxt, fail_x2_nxt;

    // Next state and sweep counter advance
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        run_start = 1'b0;
        lo_wrap   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    run_start = 1'b1;
                    state_nxt = SWEEP_A;
                    cnt_nxt   = '0;
                end
            end
            SWEEP_A: begin
                cnt_nxt.jt = (cnt.jt == PAT_LAST) ? 4'd0 : cnt.jt + 4'd1;
                if (cnt.jt == PAT_LAST)
                    cnt_nxt.it = (cnt.it == PAT_LAST) ? 4'd0 : cnt.it + 4'd1;
                lo_wrap = (cnt.jt == PAT_LAST) && (cnt.it == PAT_LAST);
            end
            SWEEP_B: begin
                cnt_nxt.r = (cnt.r == PAT_LAST) ? 4'd0 : cnt.r + 4'd1;
                if (cnt.r == PAT_LAST)
                    cnt_nxt.b = (cnt.b == B_LAST) ? 5'd0 : cnt.b + 5'd1;
                lo_wrap = (cnt.r == PAT_LAST) && (cnt.b == B_LAST);
            end
            DRAIN:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase

        // Sign bits sit between the mantissa and exponent counters in both sweeps
        if (lo_wrap) begin
            cnt_nxt.s2 = ~cnt.s2;
            if (cnt.s2)
                cnt_nxt.s1 = ~cnt.s1;
            if (cnt.s2 && cnt.s1) begin
                if (state == SWEEP_A) begin
                    cnt_nxt.j = (cnt.j == I_LAST_A) ? 8'd0 : cnt.j + 8'd1;
                    if (cnt.j == I_LAST_A) begin
                        cnt_nxt.i = cnt.i + 8'd1;
                        if (cnt.i == I_LAST_A) begin
                            cnt_nxt   = '0;
                            state_nxt = SWEEP_B;
                        end
                    end
                end else begin
                    cnt_nxt.i = cnt.i + 8'd1;
                    if (cnt.i == I_LAST_B) begin
                        cnt_nxt   = '0;
                        state_nxt = DRAIN;
                    end
                end
            end
        end
    end

    // Vector generation, result check and registered-output next values
    always_comb begin
        vec_valid = (state == SWEEP_A) || (state == SWEEP_B);
        m1        = lfsr[31:9];
        tmask     = MANT_W'((24'd1 << cnt.b) - 24'd1);
        vx1       = {cnt.s1, cnt.i, m1};
        vx2       = {cnt.s2, cnt.i, (m1 & ~tmask) | (lfsr[22:0] & tmask)};
        if (state == SWEEP_A) begin
            vx1 = {cnt.s1, cnt.i, mant_pat(cnt.it, lfsr[31:9])};
            vx2 = {cnt.s2, cnt.j, mant_pat(cnt.jt, lfsr[22:0])};
        end

        lfsr_nxt = lfsr;
        if (run_start)
            lfsr_nxt = LFSR_SEED;
        else if (vec_valid)
            lfsr_nxt = lfsr_step(lfsr);

        mismatch    = chk_valid && ((feq_y != exp_y_q) || (feq_exception != exp_exc_q));
        err_nxt     = err_count;
        fail_x1_nxt = fail_x1;
        fail_x2_nxt = fail_x2;
        if (run_start) begin
            err_nxt     = 16'd0;
            fail_x1_nxt = 32'd0;
            fail_x2_nxt = 32'd0;
        end else if (mismatch) begin
            if (err_count != 16'hFFFF)
                err_nxt = err_count + 16'd1;
            if (err_count == 16'd0) begin
                fail_x1_nxt = feq_x1;
                fail_x2_nxt = feq_x2;
            end
        end

        // busy covers the drain cycle; done follows one cycle after DONE is entered
        busy_nxt = (state_nxt == SWEEP_A) || (state_nxt == SWEEP_B) ||
                   (state_nxt == DRAIN)   || (state == DRAIN);
        done_nxt = (state == DONE) && (state_nxt == DONE);
        pass_nxt = done_nxt && (err_count == 16'd0);
    end

    feq_ref_model u_ref (
        .x1        (vx1),
        .x2        (vx2),
        .exp_y_c   (exp_y),
        .exp_exc_c (exp_exc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lfsr      <= LFSR_SEED;
            feq_x1    <= 32'd0;
            feq_x2    <= 32'd0;
            chk_valid <= 1'b0;
            exp_y_q   <= 1'b0;
            exp_exc_q <= 1'b0;
            err_count <= 16'd0;
            fail_x1   <= 32'd0;
            fail_x2   <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lfsr      <= lfsr_nxt;
            if (vec_valid) begin
                feq_x1 <= vx1;
                feq_x2 <= vx2;
            end
            chk_valid <= vec_valid;
            exp_y_q   <= exp_y;
            exp_exc_q <= exp_exc;
            err_count <= err_nxt;
            fail_x1   <= fail_x1_nxt;
            fail_x2   <= fail_x2_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
        end
    end

endmodule
